shift_right_seq_32bit: RTL

SHIFT_RIGHT_SEQ_32BIT -- requirements
Module: shift_right_seq_32bit

---
 rtl/shift_right_seq_32bit_pkg.sv | 14 +
 rtl/shift_right_seq_32bit_if.sv | 26 ++
 rtl/shift_right_seq_32bit_1bit.sv | 17 +
 rtl/shift_right_seq_32bit.sv | 103 ++++++++++
 4 files changed

// File: rtl/shift_right_seq_32bit_pkg.sv
// Shared ALU package: default widths and the sequential shifter's state encodings.
package shift_right_seq_32bit_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned SHAMT_W_DEF = 5;
  localparam int unsigned AMT_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_seq_32bit_if.sv
// Request/response bundle of the sequential right shifter.
interface shift_right_seq_32bit_if
  import shift_right_seq_32bit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] X;
  logic [AMT_W-1:0] Y;
  logic             arith;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Z;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output X, Y, arith, in_valid, out_ready,
    input  in_ready, Z, out_valid, busy
  );

  modport slave (
    input  X, Y, arith, in_valid, out_ready,
    output in_ready, Z, out_valid, busy
  );
endinterface

// File: rtl/shift_right_seq_32bit_1bit.sv
// One output bit of a right shift: word[index+amount], or fill once the source runs off the top.
module shift_right_1bit
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
)(
  input  logic [WIDTH-1:0]   word,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [SHAMT_W-1:0] index,
  input  logic               fill,
  output logic               z_bit
);
  logic [SHAMT_W:0] src;

  assign src   = {1'b0, index} + {1'b0, amount};
  assign z_bit = src[SHAMT_W] ? fill : word[src[SHAMT_W-1:0]];
endmodule

// File: rtl/shift_right_seq_32bit.sv
// Sequential right shifter: one power-of-two stage per clock, SHAMT_W stages per request.
// Define SHIFT_RIGHT_ARITH_EN to honour the arith input (sign fill); otherwise fill is always 0.
module shift_right_seq_32bit
  import shift_right_seq_32bit_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
)(
  input  logic                    clk,
  input  logic                    rst,
  shift_right_seq_32bit_if.slave  bus
);
  state_t             state;
  logic [SHAMT_W-1:0] k;
  logic [SHAMT_W-1:0] y_lat;
  logic               fill_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   stage_out;
  logic [SHAMT_W-1:0] stage_amt;
  logic [SHAMT_W-1:0] y_sh;
  logic               stage_en;
  logic               y_big;
  logic               fill_in;

`ifdef SHIFT_RIGHT_ARITH_EN
  assign fill_in = bus.arith & bus.X[WIDTH-1];
`else
  logic unused_arith;
  assign unused_arith = bus.arith;
  assign fill_in      = 1'b0;
`endif

  // Amounts of WIDTH or more leave nothing but fill bits.
  assign y_big     = |bus.Y[AMT_W-1:SHAMT_W];
  assign stage_amt = SHAMT_W'(1) << k;
  assign y_sh      = y_lat >> k;
  assign stage_en  = y_sh[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    shift_right_1bit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_bit (
      .word   (work),
      .amount (stage_amt),
      .index  (SHAMT_W'(i)),
      .fill   (fill_q),
      .z_bit  (stage_out[i])
    );
  end

  assign bus.Z = work;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      y_lat         <= '0;
      fill_q        <= 1'b0;
      work          <= '0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // An oversize amount is resolved at accept time; later stages keep the fill word intact.
            work         <= y_big ? {WIDTH{fill_in}} : bus.X;
            y_lat        <= bus.Y[SHAMT_W-1:0];
            fill_q       <= fill_in;
            k            <= '0;
            state        <= SHIFT;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        SHIFT: begin
          if (stage_en) work <= stage_out;
          if (k == SHAMT_W'(SHAMT_W - 1)) begin
            k             <= '0;
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end else begin
            k <= k + SHAMT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          k             <= '0;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule
